// File: rtl/core_issue_stage.sv
// Decode/issue stage for RV32I OP, OP-IMM and LUI: register file with write-through
// bypass, per-register scoreboard hazard stall and a one-entry ID/EX register.
module core_issue_stage #(
   parameter int DATA_WIDTH       = 32,
   parameter int ALU_WIDTH_CODE   = 3,
   parameter int SHIFT_WIDTH_CODE = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        id_valid,
   output logic                        id_ready,
   input  logic [31:0]                 id_instr,
   output logic                        ex_valid,
   input  logic                        ex_ready,
   output logic                        alu_op,
   output logic                        shift_op,
   output logic [ALU_WIDTH_CODE-1:0]   alu_control,
   output logic [SHIFT_WIDTH_CODE-1:0] shift_control,
   output logic [DATA_WIDTH-1:0]       ex_in_a,
   output logic [DATA_WIDTH-1:0]       ex_in_b,
   output logic [4:0]                  ex_rd,
   input  logic                        wb_valid,
   input  logic [4:0]                  wb_rd,
   input  logic [DATA_WIDTH-1:0]       wb_data,
   output logic                        illegal_instr
);

   localparam logic [ALU_WIDTH_CODE-1:0]   ALU_ADD   = ALU_WIDTH_CODE'(1);
   localparam logic [ALU_WIDTH_CODE-1:0]   ALU_SUB   = ALU_WIDTH_CODE'(2);
   localparam logic [ALU_WIDTH_CODE-1:0]   ALU_SLT   = ALU_WIDTH_CODE'(3);
   localparam logic [ALU_WIDTH_CODE-1:0]   ALU_SLTU  = ALU_WIDTH_CODE'(4);
   localparam logic [ALU_WIDTH_CODE-1:0]   ALU_XOR   = ALU_WIDTH_CODE'(5);
   localparam logic [ALU_WIDTH_CODE-1:0]   ALU_OR    = ALU_WIDTH_CODE'(6);
   localparam logic [ALU_WIDTH_CODE-1:0]   ALU_AND   = ALU_WIDTH_CODE'(7);
   localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SLL = SHIFT_WIDTH_CODE'(1);
   localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SRL = SHIFT_WIDTH_CODE'(2);
   localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SRA = SHIFT_WIDTH_CODE'(3);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [4:0] rs1, rs2, rd;
   assign opcode = id_instr[6:0];
   assign rd     = id_instr[11:7];
   assign f3     = id_instr[14:12];
   assign rs1    = id_instr[19:15];
   assign rs2    = id_instr[24:20];
   assign f7     = id_instr[31:25];

   logic [DATA_WIDTH-1:0] rf [0:31];
   logic [31:0]           sb, sb_next;
   logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

   // Write-through: a same-cycle writeback is visible to the decoding instruction.
   assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_valid && wb_rd == rs1) ? wb_data : rf[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_valid && wb_rd == rs2) ? wb_data : rf[rs2];

   logic                        d_legal, d_alu, d_use_rs1, d_use_rs2, is_op, f7_base, f7_alt;
   logic [ALU_WIDTH_CODE-1:0]   d_alu_ctl;
   logic [SHIFT_WIDTH_CODE-1:0] d_sh_ctl;
   logic [DATA_WIDTH-1:0]       d_a, d_b;

   assign is_op   = (opcode == OPC_OP);
   assign f7_base = (f7 == 7'b0000000);
   assign f7_alt  = (f7 == 7'b0100000);

   always_comb begin
      d_legal   = 1'b0;
      d_alu     = 1'b0;
      d_alu_ctl = '0;
      d_sh_ctl  = '0;
      d_use_rs1 = 1'b0;
      d_use_rs2 = 1'b0;
      d_a       = rs1_val;
      d_b       = rs2_val;
      if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
         d_use_rs1 = 1'b1;
         d_use_rs2 = is_op;
         if (!is_op)
            d_b = (f3 == 3'b001 || f3 == 3'b101) ? DATA_WIDTH'(id_instr[24:20])
                                                 : DATA_WIDTH'($signed(id_instr[31:20]));
         case (f3)
            3'b000: begin
               d_alu     = 1'b1;
               d_alu_ctl = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
               d_legal   = !is_op || f7_base || f7_alt;
            end
            3'b001: begin
               d_sh_ctl = SHIFT_SLL;
               d_legal  = f7_base;
            end
            3'b101: begin
               d_sh_ctl = f7_alt ? SHIFT_SRA : SHIFT_SRL;
               d_legal  = f7_base || f7_alt;
            end
            default: begin
               d_alu   = 1'b1;
               d_legal = !is_op || f7_base;
               case (f3)
                  3'b010:  d_alu_ctl = ALU_SLT;
                  3'b011:  d_alu_ctl = ALU_SLTU;
                  3'b100:  d_alu_ctl = ALU_XOR;
                  3'b110:  d_alu_ctl = ALU_OR;
                  default: d_alu_ctl = ALU_AND;
               endcase
            end
         endcase
      end else if (opcode == OPC_LUI) begin
         d_legal   = 1'b1;
         d_alu     = 1'b1;
         d_alu_ctl = ALU_ADD;
         d_a       = '0;
         d_b       = DATA_WIDTH'({id_instr[31:12], 12'b0});
      end
   end

   // A pending bit retired by this cycle's writeback no longer blocks.
   function automatic logic busy(input logic [4:0] r, input logic [31:0] sbv,
                                 input logic wbv, input logic [4:0] wbr);
      return (r != 5'd0) && sbv[r] && !(wbv && wbr == r);
   endfunction

   logic hazard, slot_free, accept, issue;
   assign hazard = (d_use_rs1 && busy(rs1, sb, wb_valid, wb_rd)) ||
                   (d_use_rs2 && busy(rs2, sb, wb_valid, wb_rd)) ||
                   busy(rd, sb, wb_valid, wb_rd);
   assign slot_free = !ex_valid || ex_ready;
   assign id_ready  = d_legal ? (!hazard && slot_free) : slot_free;
   assign accept    = id_valid && id_ready;
   assign issue     = accept && d_legal;

   always_comb begin
      sb_next = sb;
      if (wb_valid) sb_next[wb_rd] = 1'b0;
      if (issue && rd != 5'd0) sb_next[rd] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_valid && wb_rd != 5'd0) begin
         rf[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb            <= '0;
         ex_valid      <= 1'b0;
         alu_op        <= 1'b0;
         shift_op      <= 1'b0;
         alu_control   <= '0;
         shift_control <= '0;
         ex_in_a       <= '0;
         ex_in_b       <= '0;
         ex_rd         <= '0;
         illegal_instr <= 1'b0;
      end else begin
         sb            <= sb_next;
         illegal_instr <= accept && !d_legal;
         if (issue) begin
            ex_valid      <= 1'b1;
            alu_op        <= d_alu;
            shift_op      <= !d_alu;
            alu_control   <= d_alu ? d_alu_ctl : '0;
            shift_control <= d_alu ? '0 : d_sh_ctl;
            ex_in_a       <= d_a;
            ex_in_b       <= d_b;
            ex_rd         <= rd;
         end else if (ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end

endmodule
